// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        STOP   = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
    localparam int unsigned PC_INCR    = 4;

endpackage

// File: rtl/next_pc_sel.sv
// Priority redirect mux and target adders for instr_fetch.
// INSTR_FETCH_EXC_VECTOR_EN: exceptions vector to EXC_VECTOR instead of stopping.
module next_pc_sel #(
    parameter int unsigned        BITS       = 32,
    parameter int unsigned        JMP_LEFT   = 25,
    parameter int unsigned        IMM_LEFT   = 16,
    parameter logic [BITS-1:0]    EXC_VECTOR = 32'h0000_0080
) (
    input  logic                  jmp,
    input  logic                  jal,
    input  logic                  jreg,
    input  logic                  breq,
    input  logic                  brne,
    input  logic                  halt,
    input  logic                  exception,
    input  logic                  equal,
    input  logic                  not_equal,
    input  logic [JMP_LEFT:0]     addr,
    input  logic [IMM_LEFT-1:0]   imm,
    input  logic [BITS-1:0]       jreg_target,
    input  logic [BITS-1:0]       pc_plus4,
    output logic                  redirect,
    output logic                  stop,
    output logic [BITS-1:0]       target
);

    logic            taken;
    logic [BITS-1:0] imm_ext;
    logic [BITS-1:0] jmp_target;
    logic [BITS-1:0] br_target;

    always_comb begin
        taken      = (breq && equal) || (brne && not_equal);
        imm_ext    = {{(BITS-IMM_LEFT){imm[IMM_LEFT-1]}}, imm};
        jmp_target = {pc_plus4[BITS-1:JMP_LEFT+3], addr, 2'b00};
        br_target  = pc_plus4 + (imm_ext << 2);

        redirect = 1'b0;
        stop     = 1'b0;
        target   = pc_plus4;
        if (exception) begin
            redirect = 1'b1;
            target   = EXC_VECTOR;
`ifdef INSTR_FETCH_EXC_VECTOR_EN
            stop     = 1'b0;
`else
            stop     = 1'b1;
`endif
        end else if (halt) begin
            redirect = 1'b1;
            stop     = 1'b1;
        end else if (jreg) begin
            redirect = 1'b1;
            target   = jreg_target;
        end else if (jmp || jal) begin
            redirect = 1'b1;
            target   = jmp_target;
        end else if (taken) begin
            redirect = 1'b1;
            target   = br_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, fetch FSM (FETCH/SQUASH/STOP) and link value.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     BITS       = 32,
    parameter int unsigned     JMP_LEFT   = 25,
    parameter int unsigned     IMM_LEFT   = 16,
    parameter logic [BITS-1:0] RESET_PC   = BITS'(instr_fetch_pkg::RESET_PC),
    parameter logic [BITS-1:0] EXC_VECTOR = BITS'(instr_fetch_pkg::EXC_VECTOR)
) (
    input  logic                clk,
    input  logic                rst_,
    output logic [BITS-1:0]     imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic                load_instr,
    output logic [BITS-1:0]     pc_plus4,
    input  logic                jmp,
    input  logic                jal,
    input  logic                jreg,
    input  logic                breq,
    input  logic                brne,
    input  logic                halt,
    input  logic                exception,
    input  logic                equal,
    input  logic                not_equal,
    input  logic [JMP_LEFT:0]   addr,
    input  logic [IMM_LEFT-1:0] imm,
    input  logic [BITS-1:0]     jreg_target,
    output logic                halted,
    output logic [BITS-1:0]     exc_pc
);

    fetch_state_t    state_q, state_d;
    logic [BITS-1:0] pc_q, pc_d;
    logic [BITS-1:0] ctl_pc_q, ctl_pc_d;
    logic [BITS-1:0] pc_plus4_q, pc_plus4_d;
    logic [BITS-1:0] old_addr_q, old_addr_d;
    logic [BITS-1:0] exc_pc_q, exc_pc_d;
    logic            started_q;

    logic            redirect;
    logic            stop;
    logic [BITS-1:0] target;

    next_pc_sel #(
        .BITS       (BITS),
        .JMP_LEFT   (JMP_LEFT),
        .IMM_LEFT   (IMM_LEFT),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_sel (
        .jmp         (jmp),
        .jal         (jal),
        .jreg        (jreg),
        .breq        (breq),
        .brne        (brne),
        .halt        (halt),
        .exception   (exception),
        .equal       (equal),
        .not_equal   (not_equal),
        .addr        (addr),
        .imm         (imm),
        .jreg_target (jreg_target),
        .pc_plus4    (pc_plus4_q),
        .redirect    (redirect),
        .stop        (stop),
        .target      (target)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ctl_pc_d   = ctl_pc_q;
        pc_plus4_d = pc_plus4_q;
        old_addr_d = old_addr_q;
        exc_pc_d   = exc_pc_q;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        load_instr = 1'b0;
        halted     = (state_q == STOP);

        // started_q keeps the bus idle for the cycle in which reset releases
        if (started_q) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (exception) exc_pc_d = ctl_pc_q;
                    if (stop) begin
                        state_d = STOP;
                    end else if (redirect) begin
                        pc_d = target;
                        if (!imem_ack) begin
                            state_d    = SQUASH;
                            old_addr_d = pc_q;
                        end
                    end else if (imem_ack) begin
                        load_instr = 1'b1;
                        ctl_pc_d   = pc_q;
                        pc_plus4_d = pc_q + BITS'(PC_INCR);
                        pc_d       = pc_q + BITS'(PC_INCR);
                    end
                end
                SQUASH: begin
                    // the stale request must complete on the bus before refetching
                    imem_req  = 1'b1;
                    imem_addr = old_addr_q;
                    if (exception) exc_pc_d = ctl_pc_q;
                    if (stop) begin
                        state_d = STOP;
                    end else begin
                        if (redirect) pc_d = target;
                        if (imem_ack) state_d = FETCH;
                    end
                end
                STOP: ;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ctl_pc_q   <= RESET_PC;
            pc_plus4_q <= RESET_PC + BITS'(PC_INCR);
            old_addr_q <= RESET_PC;
            exc_pc_q   <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ctl_pc_q   <= ctl_pc_d;
            pc_plus4_q <= pc_plus4_d;
            old_addr_q <= old_addr_d;
            exc_pc_q   <= exc_pc_d;
            started_q  <= 1'b1;
        end
    end

    assign pc_plus4 = pc_plus4_q;
    assign exc_pc   = exc_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a behavioural fetch model.
module tb_instr_fetch;

`ifdef INSTR_FETCH_EXC_VECTOR_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif
    localparam int M_FETCH  = 0;
    localparam int M_SQUASH = 1;
    localparam int M_STOP   = 2;

    logic        clk;
    logic        rst_;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic        load_instr;
    logic [31:0] pc_plus4;
    logic        jmp, jal, jreg, breq, brne, halt, exception, equal, not_equal;
    logic [25:0] addr;
    logic [15:0] imm;
    logic [31:0] jreg_target;
    logic        halted;
    logic [31:0] exc_pc;

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst_        (rst_),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .load_instr  (load_instr),
        .pc_plus4    (pc_plus4),
        .jmp         (jmp),
        .jal         (jal),
        .jreg        (jreg),
        .breq        (breq),
        .brne        (brne),
        .halt        (halt),
        .exception   (exception),
        .equal       (equal),
        .not_equal   (not_equal),
        .addr        (addr),
        .imm         (imm),
        .jreg_target (jreg_target),
        .halted      (halted),
        .exc_pc      (exc_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Where the next fetch goes, derived directly from the redirect priority rules
    function automatic logic [31:0] model_target(input logic [31:0] p4);
        logic [31:0] sext;
        sext = {{16{imm[15]}}, imm};
        if (exception)        return 32'h0000_0080;
        if (jreg)             return jreg_target;
        if (jmp || jal)       return {p4[31:28], addr, 2'b00};
        return p4 + sext * 4;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          m_started = 0;
    int          m_mode    = M_FETCH;
    logic [31:0] m_pc = 0, m_ctl = 0, m_old = 0, m_exc = 0;

    always begin
        logic        redir, taken, stp, exp_req, exp_load;
        logic [31:0] tgt;
        @(negedge clk);
        #2;
        if (!rst_) begin
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_load", {31'd0, load_instr}, 32'd0);
            chk("rst_halted", {31'd0, halted}, 32'd0);
            chk("rst_exc_pc", exc_pc, 32'd0);
            chk("rst_pc_plus4", pc_plus4, 32'd4);
            m_started = 0; m_mode = M_FETCH;
            m_pc = 0; m_ctl = 0; m_old = 0; m_exc = 0;
        end else begin
            taken    = (breq && equal) || (brne && not_equal);
            redir    = exception || halt || jreg || jmp || jal || taken;
            exp_req  = m_started && (m_mode != M_STOP);
            exp_load = exp_req && (m_mode == M_FETCH) && imem_ack && !redir;
            chk("req", {31'd0, imem_req}, {31'd0, exp_req});
            if (exp_req)
                chk("imem_addr", imem_addr, (m_mode == M_SQUASH) ? m_old : m_pc);
            chk("load_instr", {31'd0, load_instr}, {31'd0, exp_load});
            chk("halted", {31'd0, halted}, {31'd0, (m_mode == M_STOP)});
            chk("pc_plus4", pc_plus4, m_ctl + 32'd4);
            chk("exc_pc", exc_pc, m_exc);

            if (!m_started) begin
                m_started = 1;
            end else if (m_mode != M_STOP) begin
                tgt = model_target(m_ctl + 32'd4);
                stp = exception ? !EXC_EN : halt;
                if (exception) m_exc = m_ctl;
                if (stp) begin
                    m_mode = M_STOP;
                end else if (redir) begin
                    if (m_mode == M_FETCH && !imem_ack) begin
                        m_old  = m_pc;
                        m_mode = M_SQUASH;
                    end else if (imem_ack) begin
                        m_mode = M_FETCH;
                    end
                    m_pc = tgt;
                end else if (imem_ack) begin
                    if (m_mode == M_FETCH) begin
                        m_ctl = m_pc;
                        m_pc  = m_pc + 32'd4;
                    end else begin
                        m_mode = M_FETCH;
                    end
                end
            end
        end
    end

    // ---------------- stimulus with literal checkpoints ----------------
    task automatic clr_ctl();
        jmp = 0; jal = 0; jreg = 0; breq = 0; brne = 0; halt = 0; exception = 0;
        equal = 0; not_equal = 0; addr = '0; imm = '0; jreg_target = '0;
    endtask

    task automatic step(input logic ack);
        @(negedge clk);
        clr_ctl();
        imem_ack = ack;
    endtask

    initial begin
        rst_ = 0; imem_ack = 0;
        clr_ctl();
        repeat (3) @(negedge clk);
        #3;
        chk("lit_rst_req", {31'd0, imem_req}, 32'd0);
        chk("lit_rst_pc4", pc_plus4, 32'd4);

        // reset release with a zero-wait memory
        @(negedge clk); rst_ = 1; imem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            #3;
            chk("lit_seq_addr", imem_addr, 32'(4 * i));
            chk("lit_seq_load", {31'd0, load_instr}, 32'd1);
        end

        // two wait states per word
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 3; s++) begin
                step(s == 2);
                #3;
                chk("lit_wait_addr", imem_addr, 32'(16 + 4 * w));
                chk("lit_wait_load", {31'd0, load_instr}, (s == 2) ? 32'd1 : 32'd0);
            end
        end

        // get ctl_pc to 0x100, then a taken branch while the fetch is pending
        step(1'b1); jreg = 1; jreg_target = 32'h100;
        #3; chk("lit_jr_load", {31'd0, load_instr}, 32'd0);
        step(1'b1);
        #3; chk("lit_jr_addr", imem_addr, 32'h100);
        step(1'b0); breq = 1; equal = 1; imm = 16'hFFFE;
        #3; chk("lit_br_pc4", pc_plus4, 32'h104);
        step(1'b1);
        #3;
        chk("lit_squash_addr", imem_addr, 32'h104);
        chk("lit_squash_load", {31'd0, load_instr}, 32'd0);
        step(1'b0);
        #3; chk("lit_br_target", imem_addr, 32'h0FC);

        // jump coinciding with an ack
        step(1'b1); jmp = 1; addr = 26'h40;
        #3; chk("lit_jmp_load", {31'd0, load_instr}, 32'd0);
        step(1'b0);
        #3; chk("lit_jmp_addr", imem_addr, 32'h100);

        // wrap of the PC at the top of the address space
        step(1'b1); jreg = 1; jreg_target = 32'hFFFF_FFFC;
        step(1'b1);
        #3; chk("lit_top_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b0);
        #3;
        chk("lit_wrap_addr", imem_addr, 32'h0);
        chk("lit_wrap_pc4", pc_plus4, 32'h0);

        // randomized traffic without halt/exception
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            imem_ack    = ($urandom_range(0, 2) != 0);
            jmp         = ($urandom_range(0, 15) == 0);
            jal         = ($urandom_range(0, 15) == 0);
            jreg        = ($urandom_range(0, 15) == 0);
            breq        = ($urandom_range(0, 7) == 0);
            brne        = ($urandom_range(0, 7) == 0);
            equal       = $urandom_range(0, 1) == 1;
            not_equal   = $urandom_range(0, 1) == 1;
            addr        = 26'($urandom);
            imm         = 16'($urandom);
            jreg_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            halt        = 0;
            exception   = 0;
        end

        // exception at ctl_pc=0x20
        step(1'b1);
        step(1'b1);
        step(1'b1); jreg = 1; jreg_target = 32'h20;
        step(1'b1);
        step(1'b0); exception = 1;
        step(1'b1);
        #3;
        chk("lit_exc_pc", exc_pc, 32'h20);
        if (EXC_EN) chk("lit_exc_squash", imem_addr, 32'h24);
        else        chk("lit_exc_halted", {31'd0, halted}, 32'd1);
        step(1'b0);
        #3;
        if (EXC_EN) chk("lit_exc_vector", imem_addr, 32'h80);
        else        chk("lit_exc_req", {31'd0, imem_req}, 32'd0);

        // halt, sticky stop, then reset mid-wait
        step(1'b0); halt = 1;
        for (int i = 0; i < 3; i++) begin
            step(i[0]);
            #3;
            chk("lit_stop_halted", {31'd0, halted}, 32'd1);
            chk("lit_stop_req", {31'd0, imem_req}, 32'd0);
        end
        step(1'b0); rst_ = 0;
        #3; chk("lit_rst2_halted", {31'd0, halted}, 32'd0);
        step(1'b1); rst_ = 1;
        step(1'b1);
        #3;
        chk("lit_resume_addr", imem_addr, 32'h0);
        chk("lit_resume_load", {31'd0, load_instr}, 32'd1);
        chk("lit_resume_halted", {31'd0, halted}, 32'd0);

        repeat (3) step(1'b1);
        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
